pu_or1k_branch_resolver: RTL and testbench
==========================================

// Module: pu_or1k_branch_resolver
//
// PURPOSE
// - Execute-side counterpart of the decode-stage branch predictor. Queues each
//   predicted conditional branch (l.bf/l.bnf) at decode and checks it against
//   the flag resolved at execute.
// - Issues a registered mispredict/redirect to fetch and squashes younger queued
//   predictions.
// - Trains a small 2-bit saturating-counter BHT whose taken hint decode can use.
//
// PARAMETERS
// OPTION_OPERAND_WIDTH  32  PC/target width
// BHT_INDEX_WIDTH       4   BHT has 2**BHT_INDEX_WIDTH entries, index = pc[BHT_INDEX_WIDTH+1:2]
// QUEUE_DEPTH           2   in-flight prediction slots, power of 2, >=2
// STAT_WIDTH            16  width of the statistics counters
//
// PORTS
// clk                 in   1    core clock, all state on rising edge
// rst_n               in   1    asynchronous reset, active low
// flush_i             in   1    pipeline flush (exception/rfe): drop all in-flight state
// pred_valid_i        in   1    decode pushes a conditional branch (qualified by padv)
// pred_pc_i           in   OW   PC of the branch
// pred_target_i       in   OW   branch target if taken
// pred_taken_i        in   1    flag predicted at decode
// pred_ready_o        out  1    queue not full
// res_valid_i         in   1    execute resolves the oldest queued branch
// res_flag_i          in   1    actual taken outcome
// mispredict_o        out  1    one-cycle pulse: redirect fetch
// redirect_pc_o       out  OW   corrected fetch PC, valid with mispredict_o
// bht_pc_i            in   OW   decode lookup PC
// bht_taken_o         out  1    BHT hint = counter[bht index][1], combinational
// queue_empty_o       out  1    no in-flight predictions
// err_o               out  1    sticky: resolve with empty queue or push while full
// stat_branches_o     out  SW   resolved branch count
// stat_mispredicts_o  out  SW   mispredict count
//
// BEHAVIOUR
// - Reset: queue empty, pointers 0, mispredict_o=0, redirect_pc_o=0, err_o=0,
//   stats=0, all BHT counters=2'b01 (weakly not-taken).
// - Push: happens when pred_valid_i&pred_ready_o. Stores {pc,target,taken} at the
//   write pointer. pred_ready_o=!full, so a full queue does not accept a push even
//   if a pop happens in the same cycle.
// - Push with pred_valid_i while full: the entry is dropped and err_o is set.
// - Pop: res_valid_i with the queue non-empty pops the oldest entry (FIFO order).
//   An entry pushed in the same cycle is not visible to that pop.
// - Pop with the queue empty: ignored, err_o is set.
// - Pointers wrap modulo QUEUE_DEPTH. Occupancy count is 0..QUEUE_DEPTH.
// - Mismatch = popped.taken != res_flag_i.
//   - On the next cycle: mispredict_o=1 for exactly one cycle.
//   - redirect_pc_o = res_flag_i ? target : pc+8 (delay slot), arithmetic modulo 2**OW.
//   - At the same edge the queue is cleared (younger entries are wrong-path),
//     including any same-cycle push.
// - Match: the entry is popped with no redirect, and redirect_pc_o holds its value.
// - BHT update on every pop, at the popped pc index:
//   - taken: counter increments, saturating at 3.
//   - not taken: counter decrements, saturating at 0.
//   - The lookup reads the pre-update value in the same cycle (no bypass).
// - Stats on every pop: stat_branches_o+1. On mismatch: stat_mispredicts_o+1.
//   Both wrap at 2**STAT_WIDTH.
// - flush_i has highest priority:
//   - Clears the queue.
//   - Discards any same-cycle push or pop (no BHT/stat update).
//   - Forces mispredict_o=0 on the next cycle.
//   - BHT and stats are retained.
// - err_o clears only on reset.
// - Reset asserted mid-operation: everything returns to reset values immediately.
//
// TESTING
// - Push pc=0x100,tgt=0x80,taken=1; resolve flag=1 -> no mispredict, BHT[0] 01->10,
//   branches=1.
// - Push pc=0x200,taken=0,tgt=0x300; resolve flag=1 -> next cycle mispredict_o=1,
//   redirect=0x300, mispredicts=1.
// - Push pc=0x400,taken=1,tgt=0x500; resolve flag=0 -> mispredict_o=1 for one cycle,
//   redirect=0x408.
// - Fill queue (2 pushes); resolve the oldest as a mispredict while pushing a 3rd
//   -> queue_empty_o=1 next cycle, err_o=0.
// - Resolve 4x taken at pc=0x10 -> BHT index 4 saturates at 3, bht_taken_o=1.
//   Then 4x not-taken -> saturates at 0.
// - flush_i with a same-cycle mismatching pop -> no mispredict_o, stats unchanged,
//   queue empty.
//   Then res_valid_i with the queue empty -> err_o=1.

Source files
------------

// File: rtl/pu_or1k_branch_resolver_if.sv
// Prediction push / resolve / redirect bundle between the decode and
// execute stages and the branch resolver.
interface pu_or1k_branch_resolver_if #(
  parameter int OPTION_OPERAND_WIDTH = 32
);
  localparam int OW = OPTION_OPERAND_WIDTH;

  logic          pred_valid_i;
  logic [OW-1:0] pred_pc_i;
  logic [OW-1:0] pred_target_i;
  logic          pred_taken_i;
  logic          pred_ready_o;
  logic          res_valid_i;
  logic          res_flag_i;
  logic          mispredict_o;
  logic [OW-1:0] redirect_pc_o;

  modport master (
    output pred_valid_i, pred_pc_i, pred_target_i, pred_taken_i,
    output res_valid_i, res_flag_i,
    input  pred_ready_o, mispredict_o, redirect_pc_o
  );

  modport slave (
    input  pred_valid_i, pred_pc_i, pred_target_i, pred_taken_i,
    input  res_valid_i, res_flag_i,
    output pred_ready_o, mispredict_o, redirect_pc_o
  );
endinterface

// File: rtl/pu_or1k_branch_resolver.sv
// Branch resolver: queues decode-time predictions, checks them at execute,
// redirects fetch on mispredict and trains a 2-bit BHT.
// Ports: clk, rst_n, flush_i, bus (slave: push/resolve/redirect),
// bht_pc_i/bht_taken_o lookup, queue_empty_o, err_o, stat counters.
module pu_or1k_branch_resolver #(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int BHT_INDEX_WIDTH      = 4,
  parameter int QUEUE_DEPTH          = 2,
  parameter int STAT_WIDTH           = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flush_i,
  pu_or1k_branch_resolver_if.slave        bus,
  input  logic [OPTION_OPERAND_WIDTH-1:0] bht_pc_i,
  output logic                            bht_taken_o,
  output logic                            queue_empty_o,
  output logic                            err_o,
  output logic [STAT_WIDTH-1:0]           stat_branches_o,
  output logic [STAT_WIDTH-1:0]           stat_mispredicts_o
);
  localparam int OW = OPTION_OPERAND_WIDTH;
  localparam int IW = BHT_INDEX_WIDTH;
  localparam int QD = QUEUE_DEPTH;
  localparam int PW = $clog2(QD);
  localparam int CW = PW + 1;
  localparam int NB = 1 << IW;

  logic [OW-1:0] q_pc    [QD];
  logic [OW-1:0] q_tgt   [QD];
  logic          q_taken [QD];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [1:0]    bht [NB];

  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          mismatch;
  logic          overflow;
  logic          underflow;
  logic [IW-1:0] pop_idx;
  logic [IW-1:0] look_idx;
  logic          unused_bits;

  assign full     = (count == CW'(QD));
  assign empty    = (count == '0);
  assign push     = bus.pred_valid_i & ~full & ~flush_i;
  assign pop      = bus.res_valid_i & ~empty & ~flush_i;
  assign mismatch = pop & (q_taken[rd_ptr] != bus.res_flag_i);
  // A push into a full queue alongside a redirecting pop is wrong-path
  // work that the redirect squashes anyway, so it is not an overflow.
  assign overflow  = bus.pred_valid_i & full & ~mismatch & ~flush_i;
  assign underflow = bus.res_valid_i & empty & ~flush_i;

  assign pop_idx  = q_pc[rd_ptr][IW+1:2];
  assign look_idx = bht_pc_i[IW+1:2];

  assign bus.pred_ready_o = ~full;
  assign queue_empty_o    = empty;
  assign bht_taken_o      = bht[look_idx][1];

  assign unused_bits = ^{bht_pc_i[OW-1:IW+2], bht_pc_i[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < QD; i++) begin
        q_pc[i]    <= '0;
        q_tgt[i]   <= '0;
        q_taken[i] <= 1'b0;
      end
    end else if (flush_i || mismatch) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        q_pc[wr_ptr]    <= bus.pred_pc_i;
        q_tgt[wr_ptr]   <= bus.pred_target_i;
        q_taken[wr_ptr] <= bus.pred_taken_i;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.mispredict_o  <= 1'b0;
      bus.redirect_pc_o <= '0;
    end else begin
      bus.mispredict_o <= mismatch;
      if (mismatch)
        bus.redirect_pc_o <= bus.res_flag_i ? q_tgt[rd_ptr]
                                            : q_pc[rd_ptr] + OW'(8);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_o              <= 1'b0;
      stat_branches_o    <= '0;
      stat_mispredicts_o <= '0;
    end else begin
      if (overflow || underflow) err_o <= 1'b1;
      if (pop) stat_branches_o <= stat_branches_o + 1'b1;
      if (mismatch) stat_mispredicts_o <= stat_mispredicts_o + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NB; i++) bht[i] <= 2'b01;
    end else if (pop) begin
      if (bus.res_flag_i) begin
        if (bht[pop_idx] != 2'b11) bht[pop_idx] <= bht[pop_idx] + 2'b01;
      end else begin
        if (bht[pop_idx] != 2'b00) bht[pop_idx] <= bht[pop_idx] - 2'b01;
      end
    end
  end
endmodule

// File: tb/tb_pu_or1k_branch_resolver.sv
// Randomised and directed bench for pu_or1k_branch_resolver with an
// in-bench queue-based reference model.
module tb_pu_or1k_branch_resolver;
  localparam int QD = 2;

  logic        clk = 0;
  logic        rst_n;
  logic        flush;
  logic [31:0] bht_pc;
  logic        bht_taken;
  logic        q_empty;
  logic        err;
  logic [15:0] st_br;
  logic [15:0] st_mp;

  pu_or1k_branch_resolver_if #(.OPTION_OPERAND_WIDTH(32)) bus ();

  pu_or1k_branch_resolver dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .flush_i            (flush),
    .bus                (bus.slave),
    .bht_pc_i           (bht_pc),
    .bht_taken_o        (bht_taken),
    .queue_empty_o      (q_empty),
    .err_o              (err),
    .stat_branches_o    (st_br),
    .stat_mispredicts_o (st_mp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        taken;
  } ent_t;

  ent_t        rq[$];
  int          rbht[16];
  logic [15:0] rbr;
  logic [15:0] rmp;
  logic        rerr;
  logic        rmisp;
  logic [31:0] rredir;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    rq.delete();
    foreach (rbht[i]) rbht[i] = 1;
    rbr = 0; rmp = 0; rerr = 0; rmisp = 0; rredir = 0;
  endfunction

  function automatic void model_step();
    int   pre;
    bit   mm;
    ent_t e;
    if (flush) begin
      rq.delete();
      rmisp = 0;
      return;
    end
    pre = rq.size();
    mm  = 0;
    if (bus.res_valid_i) begin
      if (pre == 0) rerr = 1;
      else begin
        e = rq.pop_front();
        rbr++;
        if (bus.res_flag_i) begin
          if (rbht[e.pc[5:2]] < 3) rbht[e.pc[5:2]]++;
        end else begin
          if (rbht[e.pc[5:2]] > 0) rbht[e.pc[5:2]]--;
        end
        if (e.taken != bus.res_flag_i) begin
          mm = 1;
          rmp++;
          rredir = bus.res_flag_i ? e.tgt : e.pc + 32'd8;
        end
      end
    end
    if (bus.pred_valid_i && !mm) begin
      if (pre == QD) rerr = 1;
      else rq.push_back('{bus.pred_pc_i, bus.pred_target_i,
                          bus.pred_taken_i});
    end
    if (mm) rq.delete();
    rmisp = mm;
  endfunction

  task automatic compare_all();
    int bi;
    bi = int'(bht_pc[5:2]);
    chk("pred_ready", 32'(bus.pred_ready_o), 32'(rq.size() < QD));
    chk("queue_empty", 32'(q_empty), 32'(rq.size() == 0));
    chk("mispredict", 32'(bus.mispredict_o), 32'(rmisp));
    chk("redirect_pc", bus.redirect_pc_o, rredir);
    chk("bht_taken", 32'(bht_taken), 32'(rbht[bi] >= 2));
    chk("err", 32'(err), 32'(rerr));
    chk("stat_branches", 32'(st_br), 32'(rbr));
    chk("stat_mispredicts", 32'(st_mp), 32'(rmp));
  endtask

  task automatic step(bit pv, logic [31:0] pc, logic [31:0] tgt, bit tk,
                      bit rv, bit rf, bit fl, logic [31:0] lpc);
    bus.pred_valid_i  = pv;
    bus.pred_pc_i     = pc;
    bus.pred_target_i = tgt;
    bus.pred_taken_i  = tk;
    bus.res_valid_i   = rv;
    bus.res_flag_i    = rf;
    flush             = fl;
    bht_pc            = lpc;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(logic [31:0] lpc);
    step(0, 0, 0, 0, 0, 0, 0, lpc);
  endtask

  task automatic push(logic [31:0] pc, logic [31:0] tgt, bit tk);
    step(1, pc, tgt, tk, 0, 0, 0, pc);
  endtask

  task automatic resolve(bit rf, logic [31:0] lpc);
    step(0, 0, 0, 0, 1, rf, 0, lpc);
  endtask

  initial begin
    rst_n = 0;
    flush = 0;
    bht_pc = 0;
    bus.pred_valid_i = 0;
    bus.pred_pc_i = 0;
    bus.pred_target_i = 0;
    bus.pred_taken_i = 0;
    bus.res_valid_i = 0;
    bus.res_flag_i = 0;
    model_reset();
    repeat (3) @(negedge clk);
    compare_all();
    chk("reset_empty", 32'(q_empty), 32'd1);
    chk("reset_bht", 32'(bht_taken), 32'd0);
    rst_n = 1;
    @(negedge clk);

    push(32'h100, 32'h80, 1);
    resolve(1, 32'h100);
    chk("t1_bht0_taken", 32'(bht_taken), 32'd1);
    chk("t1_branches", 32'(st_br), 32'd1);
    chk("t1_no_misp", 32'(bus.mispredict_o), 32'd0);

    push(32'h200, 32'h300, 0);
    resolve(1, 32'h0);
    chk("t2_misp", 32'(bus.mispredict_o), 32'd1);
    chk("t2_redirect", bus.redirect_pc_o, 32'h300);
    chk("t2_mispredicts", 32'(st_mp), 32'd1);

    push(32'h400, 32'h500, 1);
    resolve(0, 32'h0);
    chk("t3_redirect", bus.redirect_pc_o, 32'h408);
    idle(0);
    chk("t3_pulse_end", 32'(bus.mispredict_o), 32'd0);

    push(32'h600, 32'h700, 1);
    push(32'h604, 32'h800, 0);
    chk("t4_full", 32'(bus.pred_ready_o), 32'd0);
    step(1, 32'h608, 32'h900, 1, 1, 0, 0, 0);
    chk("t4_empty", 32'(q_empty), 32'd1);
    chk("t4_err", 32'(err), 32'd0);

    repeat (4) begin
      push(32'h10, 32'h40, 1);
      resolve(1, 32'h10);
    end
    chk("t5_sat_taken", 32'(bht_taken), 32'd1);
    repeat (4) begin
      push(32'h10, 32'h40, 0);
      resolve(0, 32'h10);
    end
    chk("t5_sat_not", 32'(bht_taken), 32'd0);
    push(32'h10, 32'h40, 0);
    resolve(1, 32'h10);
    chk("t5_from_zero", 32'(bht_taken), 32'd0);

    push(32'h20, 32'h30, 1);
    step(0, 0, 0, 0, 1, 0, 1, 0);
    chk("t6_no_misp", 32'(bus.mispredict_o), 32'd0);
    chk("t6_branches", 32'(st_br), 32'd13);
    chk("t6_mispredicts", 32'(st_mp), 32'd4);
    chk("t6_empty", 32'(q_empty), 32'd1);
    resolve(1, 0);
    chk("t6_err", 32'(err), 32'd1);

    push(32'h40, 32'h50, 1);
    push(32'h44, 32'h54, 0);
    #2 rst_n = 0;
    #1 model_reset();
    compare_all();
    chk("rst_mid_err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1;
    idle(0);

    for (int i = 0; i < 600; i++) begin
      logic [31:0] pc;
      pc = {24'h0, 6'($urandom), 2'b00};
      step(($urandom_range(0, 1) == 1), pc, $urandom & 32'hffff_fffc,
           $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0,
           $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0,
           {26'h0, 4'($urandom), 2'b00});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
